// File: rtl/render_cmd_sequencer_if.sv
// Command handshake between the host-side command decoder and render_cmd_sequencer.
// The master pushes {op,start,end} with cmd_valid. The slave accepts the command on
// any clock edge where cmd_ready is also high.
interface render_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [16:0] cmd_start;
  logic [16:0] cmd_end;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_start,
    output cmd_end,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_start,
    input  cmd_end,
    output cmd_ready
  );
endinterface

// File: rtl/render_cmd_sequencer.sv
// render_cmd_sequencer: queues host render commands and issues them one at a time to
// render_module. It presents start_l/end_l/op for SETUP_CYCLES cycles before it raises
// render_enable, and it holds render_enable high until render_done arrives.
// Optional feature: define RENDER_TIMEOUT_EN to add a RUN-state watchdog that aborts
// after TIMEOUT_CYCLES. Without it, timeout_err is tied low.
module render_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETUP_CYCLES   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          n_rst,
  render_cmd_sequencer_if.slave         cmd,
  output logic [16:0]                   start_l,
  output logic [16:0]                   end_l,
  output logic [2:0]                    op,
  output logic                          render_enable,
  input  logic                          render_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          cmd_done,
  output logic                          cmd_err,
  output logic                          timeout_err
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned SW    = $clog2(SETUP_CYCLES + 1);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [SW-1:0]    SETUP_LAST = SW'(SETUP_CYCLES - 1);

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_NOOP  = 3'd1;
  localparam logic [2:0] OP_DRAW  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_RUN,
    S_GAP
  } state_t;

  state_t state, state_nxt;

  // Command FIFO storage and the latched head entry that LOAD inspects.
  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    hd_op;
  logic [16:0]   hd_start, hd_end;
  logic          push, pop;

  logic [SW-1:0] setup_cnt, setup_cnt_nxt;
  logic [16:0]   start_nxt, end_nxt;
  logic [2:0]    op_nxt;
  logic          en_nxt, done_nxt, err_nxt;

  assign cmd.cmd_ready = (fifo_count != DEPTH_C);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;

  function automatic logic pt_ok(input logic [16:0] p);
    return (p[16:8] <= 9'd319) && (p[7:0] <= 8'd239);
  endfunction

  // FIFO entry write. The storage needs no reset because the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_start, cmd.cmd_end};
  end

  // FIFO pointers, occupancy, and capture of the head entry on pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hd_op      <= '0;
      hd_start   <= '0;
      hd_end     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                      <= rd_ptr + 1'b1;
        {hd_op, hd_start, hd_end}   <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RENDER_TIMEOUT_EN
  localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] wd_cnt, wd_nxt;
  logic        tmo_nxt;

  // Watchdog count of RUN cycles, plus the registered abort pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt      <= wd_nxt;
      timeout_err <= tmo_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Next state and next registered outputs. Pulses default low; operands default to holding.
  always_comb begin
    state_nxt     = state;
    setup_cnt_nxt = setup_cnt;
    start_nxt     = start_l;
    end_nxt       = end_l;
    op_nxt        = op;
    en_nxt        = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    pop           = 1'b0;
`ifdef RENDER_TIMEOUT_EN
    wd_nxt        = wd_cnt;
    tmo_nxt       = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        setup_cnt_nxt = '0;
`ifdef RENDER_TIMEOUT_EN
        wd_nxt        = '0;
`endif
        if (hd_op == OP_NOOP) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (hd_op == OP_CLEAR) begin
          start_nxt = '0;
          end_nxt   = '0;
          op_nxt    = OP_CLEAR;
          state_nxt = S_SETUP;
        end else if (hd_op == OP_DRAW && pt_ok(hd_start) && pt_ok(hd_end)) begin
          start_nxt = hd_start;
          end_nxt   = hd_end;
          op_nxt    = OP_DRAW;
          state_nxt = S_SETUP;
        end else begin
          err_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          en_nxt    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          setup_cnt_nxt = setup_cnt + 1'b1;
        end
      end
      S_RUN: begin
        en_nxt = 1'b1;
        if (render_done) begin
          en_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_GAP;
        end
`ifdef RENDER_TIMEOUT_EN
        else if (wd_cnt == WD_LIMIT) begin
          en_nxt    = 1'b0;
          done_nxt  = 1'b1;
          tmo_nxt   = 1'b1;
          state_nxt = S_GAP;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
`endif
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered outputs. busy is derived from the next state, so it
  // tracks "not IDLE" with no extra cycle of lag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      setup_cnt     <= '0;
      start_l       <= '0;
      end_l         <= '0;
      op            <= OP_NOOP;
      render_enable <= 1'b0;
      busy          <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      setup_cnt     <= setup_cnt_nxt;
      start_l       <= start_nxt;
      end_l         <= end_nxt;
      op            <= op_nxt;
      render_enable <= en_nxt;
      busy          <= (state_nxt != S_IDLE);
      cmd_done      <= done_nxt;
      cmd_err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Self-checking bench for render_cmd_sequencer. A render_module stand-in answers
// render_enable after a programmable delay. A negedge monitor records issued commands,
// enable timing and pulse counts. The tests compare that record with expectations
// derived from the command rules.
module tb_render_cmd_sequencer;
  localparam int unsigned SETUP = 3;
`ifdef RENDER_TIMEOUT_EN
  localparam int unsigned TMO = 50;
`else
  localparam int unsigned TMO = 100000;
`endif

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic [16:0] start_l, end_l;
  logic [2:0]  op;
  logic        render_enable, render_done, busy, cmd_done, cmd_err, timeout_err;
  logic [2:0]  fifo_count;

  render_cmd_sequencer_if cif();

  render_cmd_sequencer #(
    .FIFO_DEPTH     (4),
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (tb_clk),
    .n_rst         (n_rst),
    .cmd           (cif),
    .start_l       (start_l),
    .end_l         (end_l),
    .op            (op),
    .render_enable (render_enable),
    .render_done   (render_done),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .cmd_done      (cmd_done),
    .cmd_err       (cmd_err),
    .timeout_err   (timeout_err)
  );

  always #5 tb_clk = ~tb_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // render_module stand-in: raise render_done once enable has been high done_delay cycles
  // (0 = never answer).
  int unsigned done_delay = 5;
  int unsigned run_cnt;
  initial begin
    render_done = 1'b0;
    run_cnt     = 0;
    forever begin
      @(posedge tb_clk); #1;
      if (render_enable) run_cnt++; else run_cnt = 0;
      render_done = (done_delay != 0) && render_enable && (run_cnt >= done_delay);
    end
  end

  // Monitor: the only writer of the observation record below.
  logic [36:0] issued[$];
  int unsigned high_lens[$];
  int unsigned n_done = 0, n_err = 0, n_tmo = 0, n_gap_viol = 0, n_unstable = 0;
  int unsigned low_run = 0, high_run = 0, stable_run = 0;
  bit          prev_en = 1'b0, seen_fall = 1'b0;
  logic [36:0] prev_ops = '0, ops_now;
  always @(negedge tb_clk) begin
    ops_now = {op, start_l, end_l};
    if (!n_rst) begin
      prev_en = 1'b0; seen_fall = 1'b0; low_run = 0; high_run = 0; stable_run = 0;
    end else begin
      if (cmd_done) n_done++;
      if (cmd_err) n_err++;
      if (timeout_err) n_tmo++;
      if (ops_now == prev_ops) stable_run++; else stable_run = 1;
      if (render_enable && !prev_en) begin
        issued.push_back(ops_now);
        if (seen_fall && low_run < 2) n_gap_viol++;
        if (stable_run < SETUP + 1) n_unstable++;
      end
      if (render_enable && prev_en && ops_now != prev_ops) n_unstable++;
      if (!render_enable && prev_en) begin
        high_lens.push_back(high_run);
        seen_fall = 1'b1;
      end
      if (render_enable) begin
        high_run = prev_en ? high_run + 1 : 1;
        low_run  = 0;
      end else begin
        low_run++;
      end
    end
    prev_en  = render_enable;
    prev_ops = ops_now;
  end

  function automatic bit coord_ok(input logic [16:0] p);
    int unsigned x, y;
    x = p[16:8];
    y = p[7:0];
    return (x < 320) && (y < 240);
  endfunction

  task automatic send_cmd(input logic [2:0] o, input logic [16:0] s, input logic [16:0] e,
                          output bit ok);
    ok = 1'b0;
    cif.cmd_valid = 1'b1; cif.cmd_op = o; cif.cmd_start = s; cif.cmd_end = e;
    for (int i = 0; i < 2000; i++) begin
      @(negedge tb_clk);
      if (cif.cmd_ready) ok = 1'b1;
      @(posedge tb_clk); #1;
      if (ok) break;
    end
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge tb_clk); #1;
      if (!busy && fifo_count == 3'd0 && !render_enable) begin ok = 1'b1; break; end
    end
    repeat (3) begin @(posedge tb_clk); #1; end
  endtask

  task automatic wait_enable(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge tb_clk); #1;
      if (render_enable) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_start = '0; cif.cmd_end = '0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk); n_rst = 1'b1;
    @(posedge tb_clk); #1;
    n_checks++; if (render_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", render_enable); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (op !== 3'd1) $display("FAIL reset_op: got %0d want 1", op); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (cif.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cif.cmd_ready); else n_pass++;
    n_checks++; if ({cmd_done, cmd_err, timeout_err} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {cmd_done, cmd_err, timeout_err}); else n_pass++;
    n_checks++; if ({start_l, end_l} !== 34'd0) $display("FAIL reset_operands: got %h want 0", {start_l, end_l}); else n_pass++;
  endtask

  task automatic test_draw;
    logic [16:0] s, e;
    int unsigned b_iss, b_done, b_err, b_hl, b_uns, lat;
    bit ok, ok2;
    s = {9'd10, 8'd10}; e = {9'd12, 8'd12};
    done_delay = 5;
    b_iss = issued.size(); b_done = n_done; b_err = n_err; b_hl = high_lens.size(); b_uns = n_unstable;
    send_cmd(3'd6, s, e, ok);
    lat = 0; ok2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge tb_clk); #1; lat++;
      if (render_enable) begin ok2 = 1'b1; break; end
    end
    n_checks++; if (!(ok && ok2) || lat != SETUP + 2) $display("FAIL draw_latency: got %0d edges want %0d", lat, SETUP + 2); else n_pass++;
    wait_idle(200, ok);
    n_checks++; if (!ok) $display("FAIL draw_idle: busy=%b count=%0d want idle", busy, fifo_count); else n_pass++;
    n_checks++; if (issued.size() != b_iss + 1) $display("FAIL draw_issue_count: got %0d want 1", issued.size() - b_iss); else n_pass++;
    if (issued.size() > b_iss) begin
      n_checks++; if (issued[b_iss] !== {3'd6, s, e}) $display("FAIL draw_operands: got %h want %h", issued[b_iss], {3'd6, s, e}); else n_pass++;
    end
    if (high_lens.size() > b_hl) begin
      n_checks++; if (high_lens[b_hl] != 5) $display("FAIL draw_enable_len: got %0d want 5", high_lens[b_hl]); else n_pass++;
    end
    n_checks++; if (n_unstable != b_uns) $display("FAIL draw_setup_stable: got %0d violations want 0", n_unstable - b_uns); else n_pass++;
    n_checks++; if (n_done - b_done != 1) $display("FAIL draw_done: got %0d want 1", n_done - b_done); else n_pass++;
    n_checks++; if (n_err != b_err) $display("FAIL draw_err: got %0d want 0", n_err - b_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL draw_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_fifo_full;
    int unsigned b_iss, b_done, b_gap;
    bit ok, all_ok;
    b_iss = issued.size(); b_done = n_done; b_gap = n_gap_viol;
    done_delay = 0;
    send_cmd(3'd6, {9'd5, 8'd6}, {9'd7, 8'd8}, all_ok);
    wait_enable(50, ok); all_ok &= ok;
    for (int i = 0; i < 4; i++) begin
      send_cmd(3'd0, 17'($urandom_range(1, 17'h1FFFF)), 17'($urandom_range(1, 17'h1FFFF)), ok);
      all_ok &= ok;
      if (i == 2) begin
        n_checks++; if (cif.cmd_ready !== 1'b1) $display("FAIL full_ready_at3: got %b want 1", cif.cmd_ready); else n_pass++;
      end
    end
    n_checks++; if (!all_ok) $display("FAIL full_pushes: got refused want accepted"); else n_pass++;
    n_checks++; if (fifo_count !== 3'd4) $display("FAIL full_count: got %0d want 4", fifo_count); else n_pass++;
    n_checks++; if (cif.cmd_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", cif.cmd_ready); else n_pass++;
    cif.cmd_valid = 1'b1; cif.cmd_op = 3'd1;
    @(posedge tb_clk); #1;
    cif.cmd_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd4) $display("FAIL full_fifth_refused: got count %0d want 4", fifo_count); else n_pass++;
    done_delay = 3;
    wait_idle(500, ok);
    n_checks++; if (!ok) $display("FAIL full_idle: busy=%b count=%0d want idle", busy, fifo_count); else n_pass++;
    n_checks++; if (issued.size() != b_iss + 5) $display("FAIL full_issue_count: got %0d want 5", issued.size() - b_iss); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      if (issued.size() > b_iss + i) begin
        n_checks++; if (issued[b_iss + i] !== 37'd0) $display("FAIL full_clear%0d: got %h want 0", i, issued[b_iss + i]); else n_pass++;
      end
    end
    n_checks++; if (n_gap_viol != b_gap) $display("FAIL full_gap: got %0d short gaps want 0", n_gap_viol - b_gap); else n_pass++;
    n_checks++; if (n_done - b_done != 5) $display("FAIL full_done: got %0d want 5", n_done - b_done); else n_pass++;
  endtask

  task automatic test_illegal;
    int unsigned b_iss, b_done, b_err;
    bit ok, all_ok;
    b_iss = issued.size(); b_done = n_done; b_err = n_err;
    done_delay = 5;
    send_cmd(3'd1, {9'd1, 8'd1}, {9'd2, 8'd2}, all_ok);
    send_cmd(3'd3, {9'd1, 8'd1}, {9'd2, 8'd2}, ok); all_ok &= ok;
    send_cmd(3'd6, {9'd320, 8'd10}, {9'd10, 8'd10}, ok); all_ok &= ok;
    wait_idle(200, ok); all_ok &= ok;
    n_checks++; if (!all_ok) $display("FAIL illegal_flow: handshake or idle timeout"); else n_pass++;
    n_checks++; if (issued.size() != b_iss) $display("FAIL illegal_no_enable: got %0d issues want 0", issued.size() - b_iss); else n_pass++;
    n_checks++; if (n_done - b_done != 3) $display("FAIL illegal_done: got %0d want 3", n_done - b_done); else n_pass++;
    n_checks++; if (n_err - b_err != 2) $display("FAIL illegal_err: got %0d want 2", n_err - b_err); else n_pass++;
  endtask

  task automatic test_boundary;
    int unsigned b_iss, b_done, b_err;
    logic [16:0] corner;
    bit ok, all_ok;
    corner = {9'd319, 8'd239};
    b_iss = issued.size(); b_done = n_done; b_err = n_err;
    send_cmd(3'd6, corner, corner, all_ok);
    send_cmd(3'd6, {9'd0, 8'd0}, {9'd100, 8'd240}, ok); all_ok &= ok;
    wait_idle(200, ok); all_ok &= ok;
    n_checks++; if (!all_ok) $display("FAIL bound_flow: handshake or idle timeout"); else n_pass++;
    n_checks++; if (issued.size() != b_iss + 1) $display("FAIL bound_issue_count: got %0d want 1", issued.size() - b_iss); else n_pass++;
    if (issued.size() > b_iss) begin
      n_checks++; if (issued[b_iss] !== {3'd6, corner, corner}) $display("FAIL bound_pixel: got %h want %h", issued[b_iss], {3'd6, corner, corner}); else n_pass++;
    end
    n_checks++; if (n_err - b_err != 1) $display("FAIL bound_err: got %0d want 1", n_err - b_err); else n_pass++;
    n_checks++; if (n_done - b_done != 2) $display("FAIL bound_done: got %0d want 2", n_done - b_done); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int unsigned b_iss;
    bit ok, all_ok;
    done_delay = 0;
    send_cmd(3'd6, {9'd20, 8'd30}, {9'd40, 8'd50}, all_ok);
    wait_enable(50, ok); all_ok &= ok;
    send_cmd(3'd0, '0, '0, ok); all_ok &= ok;
    send_cmd(3'd6, {9'd1, 8'd2}, {9'd3, 8'd4}, ok); all_ok &= ok;
    n_checks++; if (!all_ok || fifo_count !== 3'd2 || render_enable !== 1'b1) $display("FAIL midrst_setup: count=%0d en=%b want 2,1", fifo_count, render_enable); else n_pass++;
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if (render_enable !== 1'b0) $display("FAIL midrst_enable: got %b want 0", render_enable); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL midrst_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    @(negedge tb_clk); #2;
    n_rst = 1'b1;
    done_delay = 5;
    b_iss = issued.size();
    repeat (20) begin @(posedge tb_clk); #1; end
    n_checks++; if (issued.size() != b_iss) $display("FAIL midrst_discard: got %0d issues want 0", issued.size() - b_iss); else n_pass++;
    n_checks++; if (busy !== 1'b0 || cif.cmd_ready !== 1'b1) $display("FAIL midrst_idle: busy=%b ready=%b want 0,1", busy, cif.cmd_ready); else n_pass++;
  endtask

  task automatic test_random;
    logic [36:0] exp_q[$];
    logic [2:0]  o;
    logic [16:0] s, e;
    int unsigned b_iss, b_done, b_err, b_gap, b_uns, exp_err, r;
    int unsigned n_cmd;
    bit ok, all_ok;
    n_cmd = 30; exp_err = 0; all_ok = 1'b1;
    b_iss = issued.size(); b_done = n_done; b_err = n_err; b_gap = n_gap_viol; b_uns = n_unstable;
    done_delay = $urandom_range(1, 6);
    for (int unsigned i = 0; i < n_cmd; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) o = 3'd0;
      else if (r < 5) o = 3'd1;
      else if (r < 9) o = 3'd6;
      else begin
        r = $urandom_range(0, 4);
        case (r)
          0: o = 3'd2;
          1: o = 3'd3;
          2: o = 3'd4;
          3: o = 3'd5;
          default: o = 3'd7;
        endcase
      end
      s = {9'($urandom_range(0, 330)), 8'($urandom_range(0, 250))};
      e = ($urandom_range(0, 3) == 0) ? s : {9'($urandom_range(0, 330)), 8'($urandom_range(0, 250))};
      if (o == 3'd0) exp_q.push_back(37'd0);
      else if (o == 3'd6 && coord_ok(s) && coord_ok(e)) exp_q.push_back({o, s, e});
      else if (o != 3'd1) exp_err++;
      send_cmd(o, s, e, ok); all_ok &= ok;
      repeat ($urandom_range(0, 3)) begin @(posedge tb_clk); #1; end
    end
    wait_idle(5000, ok); all_ok &= ok;
    n_checks++; if (!all_ok) $display("FAIL rand_flow: handshake or idle timeout"); else n_pass++;
    n_checks++; if (issued.size() - b_iss != exp_q.size()) $display("FAIL rand_issue_count: got %0d want %0d", issued.size() - b_iss, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (issued.size() > b_iss + i) begin
        n_checks++; if (issued[b_iss + i] !== exp_q[i]) $display("FAIL rand_issue%0d: got %h want %h", i, issued[b_iss + i], exp_q[i]); else n_pass++;
      end
    end
    n_checks++; if (n_done - b_done != n_cmd) $display("FAIL rand_done: got %0d want %0d", n_done - b_done, n_cmd); else n_pass++;
    n_checks++; if (n_err - b_err != exp_err) $display("FAIL rand_err: got %0d want %0d", n_err - b_err, exp_err); else n_pass++;
    n_checks++; if (n_gap_viol != b_gap) $display("FAIL rand_gap: got %0d short gaps want 0", n_gap_viol - b_gap); else n_pass++;
    n_checks++; if (n_unstable != b_uns) $display("FAIL rand_stable: got %0d violations want 0", n_unstable - b_uns); else n_pass++;
  endtask

`ifdef RENDER_TIMEOUT_EN
  task automatic test_timeout;
    int unsigned b_iss, b_done, b_tmo, b_hl;
    logic [16:0] bs, be;
    bit ok, all_ok;
    bs = {9'd3, 8'd3}; be = {9'd4, 8'd4};
    b_iss = issued.size(); b_done = n_done; b_tmo = n_tmo; b_hl = high_lens.size();
    done_delay = 0;
    send_cmd(3'd6, {9'd1, 8'd1}, {9'd2, 8'd2}, all_ok);
    send_cmd(3'd6, bs, be, ok); all_ok &= ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge tb_clk); #1;
      if (n_tmo != b_tmo) begin ok = 1'b1; break; end
    end
    all_ok &= ok;
    done_delay = 3;
    wait_idle(300, ok); all_ok &= ok;
    n_checks++; if (!all_ok) $display("FAIL tmo_flow: handshake, abort or idle timeout"); else n_pass++;
    if (high_lens.size() > b_hl) begin
      n_checks++; if (high_lens[b_hl] != TMO) $display("FAIL tmo_len: got %0d want %0d", high_lens[b_hl], TMO); else n_pass++;
    end
    n_checks++; if (n_tmo - b_tmo != 1) $display("FAIL tmo_pulse: got %0d want 1", n_tmo - b_tmo); else n_pass++;
    n_checks++; if (issued.size() != b_iss + 2) $display("FAIL tmo_issue_count: got %0d want 2", issued.size() - b_iss); else n_pass++;
    if (issued.size() > b_iss + 1) begin
      n_checks++; if (issued[b_iss + 1] !== {3'd6, bs, be}) $display("FAIL tmo_next: got %h want %h", issued[b_iss + 1], {3'd6, bs, be}); else n_pass++;
    end
    n_checks++; if (n_done - b_done != 2) $display("FAIL tmo_done: got %0d want 2", n_done - b_done); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_draw();
    test_fifo_full();
    test_illegal();
    test_boundary();
    test_reset_mid_run();
    test_random();
`ifdef RENDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
